hw_sw_csr_bank: RTL

Parametrised successor to the single-port software register interface: one Avalon-style slave that gives software a control word, per-egress-port metadata submission FIFOs, per-port egress readback registers, status/level visibility, and a maskable sticky interrupt. It sits between the HPS bridge and the switch core: metadata words written by software stream to the ingress schedulers, and egress words from the core are captured for software to pop.

---
 rtl/hw_sw_csr_bank.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/hw_sw_csr_bank.sv
// Avalon-style CSR bank between the HPS bridge and switch core: control word,
// per-port metadata FIFOs, egress capture registers and a maskable sticky irq.
module hw_sw_csr_bank #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned META_DEPTH = 8,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          chipselect,
  input  logic                          write,
  input  logic                          read,
  input  logic [ADDR_W-1:0]             address,
  input  logic [DATA_W-1:0]             writedata,
  output logic [DATA_W-1:0]             readdata,
  output logic [DATA_W-1:0]             ctrl,
  output logic [NUM_PORTS-1:0]          meta_valid,
  output logic [NUM_PORTS*DATA_W-1:0]   meta_data,
  input  logic [NUM_PORTS-1:0]          meta_ready,
  input  logic [NUM_PORTS-1:0]          egr_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]   egr_data,
  output logic [NUM_PORTS-1:0]          egr_ready,
  output logic                          irq
);

  localparam int unsigned PTR_W  = $clog2(META_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned IRQ_W  = 8;
  localparam int unsigned A_META = 4;
  localparam int unsigned A_EGR  = 8;

  localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_IRQ_STAT = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_IRQ_MASK = ADDR_W'(3);

  logic wr_en, rd_en, flush;

  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic [IRQ_W-1:0]  irq_stat_q, irq_stat_d;
  logic [IRQ_W-1:0]  irq_mask_q, irq_mask_d;
  logic [IRQ_W-1:0]  irq_set, irq_clr;
  logic              irq_q, irq_d;

  logic [DATA_W-1:0] mem_q    [NUM_PORTS][META_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_PORTS];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_PORTS];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_PORTS];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_PORTS];
  logic [LVL_W-1:0]  count_q  [NUM_PORTS];
  logic [LVL_W-1:0]  count_d  [NUM_PORTS];
  logic [NUM_PORTS-1:0] full, empty, push, pop, ovf;

  logic [NUM_PORTS-1:0] held_q, held_d, cap, egr_pop;
  logic [DATA_W-1:0]    egr_q [NUM_PORTS];
  logic [DATA_W-1:0]    egr_d [NUM_PORTS];

  assign wr_en = chipselect & write;
  assign rd_en = chipselect & read;
  assign flush = wr_en && (address == A_CTRL) && writedata[DATA_W-1];

  assign ctrl       = ctrl_q;
  assign readdata   = readdata_q;
  assign irq        = irq_q;
  assign meta_valid = ~empty;
  assign egr_ready  = ~held_q & {NUM_PORTS{reset}};

  // Metadata FIFOs: fullness judged on pre-cycle occupancy, flush wins over all
  always_comb begin
    meta_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      full[p]  = (count_q[p] == LVL_W'(META_DEPTH));
      empty[p] = (count_q[p] == '0);
      push[p]  = wr_en && (address == ADDR_W'(A_META + p)) && !full[p] && !flush;
      ovf[p]   = wr_en && (address == ADDR_W'(A_META + p)) && full[p];
      pop[p]   = !empty[p] && meta_ready[p];
      meta_data[p*DATA_W +: DATA_W] = mem_q[p][rd_ptr_q[p]];
      wr_ptr_d[p] = wr_ptr_q[p] + PTR_W'(push[p]);
      rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(pop[p]);
      count_d[p]  = count_q[p] + LVL_W'(push[p]) - LVL_W'(pop[p]);
      if (flush) begin
        wr_ptr_d[p] = '0;
        rd_ptr_d[p] = '0;
        count_d[p]  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push[p]) mem_q[p][wr_ptr_q[p]] <= writedata;
    end
  end

  // Egress capture: a held word is released only by a read of its EGR address
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      cap[p]     = egr_valid[p] && egr_ready[p];
      egr_pop[p] = rd_en && (address == ADDR_W'(A_EGR + p)) && held_q[p];
      held_d[p]  = held_q[p];
      egr_d[p]   = egr_q[p];
      if (cap[p]) begin
        held_d[p] = 1'b1;
        egr_d[p]  = egr_data[p*DATA_W +: DATA_W];
      end else if (egr_pop[p]) begin
        held_d[p] = 1'b0;
      end
    end
  end

  // Control, mask and sticky status; a same-cycle set beats a W1C clear
  always_comb begin
    irq_set    = {4'(ovf), 4'(cap)};
    irq_clr    = (wr_en && (address == A_IRQ_STAT)) ? writedata[IRQ_W-1:0] : '0;
    irq_stat_d = (irq_stat_q & ~irq_clr) | irq_set;
    irq_mask_d = (wr_en && (address == A_IRQ_MASK)) ? writedata[IRQ_W-1:0] : irq_mask_q;
    ctrl_d     = (wr_en && (address == A_CTRL)) ? {1'b0, writedata[DATA_W-2:0]} : ctrl_q;
    irq_d      = |(irq_stat_q & irq_mask_q);
  end

  // Read mux observes pre-write state; readdata holds between reads
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d = '0;
      case (address)
        A_CTRL:     readdata_d = ctrl_q;
        A_STATUS:   readdata_d = DATA_W'({4'(held_q), 4'(empty), 4'(full)});
        A_IRQ_STAT: readdata_d = DATA_W'(irq_stat_q);
        A_IRQ_MASK: readdata_d = DATA_W'(irq_mask_q);
        default:    ;
      endcase
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (address == ADDR_W'(A_META + p)) readdata_d = DATA_W'(count_q[p]);
        if ((address == ADDR_W'(A_EGR + p)) && held_q[p]) readdata_d = egr_q[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q     <= '0;
      readdata_q <= '0;
      irq_stat_q <= '0;
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
      held_q     <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        count_q[p]  <= '0;
        egr_q[p]    <= '0;
      end
    end else begin
      ctrl_q     <= ctrl_d;
      readdata_q <= readdata_d;
      irq_stat_q <= irq_stat_d;
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
      held_q     <= held_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p] <= wr_ptr_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
        count_q[p]  <= count_d[p];
        egr_q[p]    <= egr_d[p];
      end
    end
  end

endmodule
